// File: rtl/dma_sram_reader.sv
// SRAM read stage for the DMA address stream: issues reads, tracks them through a
// fixed-latency pipe and buffers returned words in a credit-guarded output FIFO.
module dma_sram_reader #(
    parameter int AW  = 14,
    parameter int DW  = 32,
    parameter int IFW = 4,
    parameter int RL  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [AW-1:0]  m_addr,
    input  logic [IFW-1:0] m_info,
    input  logic           m_first,
    input  logic           m_last,
    input  logic           m_valid,
    output logic           m_ready,
    output logic           mem_en,
    output logic [AW-1:0]  mem_addr,
    input  logic [DW-1:0]  mem_rdata,
    output logic [DW-1:0]  s_data,
    output logic [IFW-1:0] s_info,
    output logic           s_first,
    output logic           s_last,
    output logic           s_valid,
    input  logic           s_ready,
    output logic           busy
);

    localparam int FD = RL + 2;
    localparam int CW = $clog2(FD + 1);
    localparam int PW = $clog2(FD);
    localparam int SW = IFW + 2;
    localparam int EW = DW + SW;

    logic          issue;
    logic          ret;
    logic          pop;
    logic [CW:0]   credit_sum;

    logic [CW-1:0] inflight_cnt_q, inflight_cnt_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic [RL-1:0] pipe_vld_q;
    logic [SW-1:0] pipe_side_q [RL];
    logic [EW-1:0] fifo_mem_q [FD];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit covers every word not yet popped, so a return always finds a free slot.
    assign credit_sum = {1'b0, inflight_cnt_q} + {1'b0, fifo_cnt_q};
    assign m_ready    = credit_sum < (CW + 1)'(FD);
    assign issue      = m_valid & m_ready;
    assign mem_en     = issue;
    assign mem_addr   = m_addr;

    assign ret     = pipe_vld_q[RL-1];
    assign s_valid = (fifo_cnt_q != '0);
    assign pop     = s_valid & s_ready;
    assign {s_data, s_info, s_first, s_last} = fifo_mem_q[rd_ptr_q];
    assign busy    = (inflight_cnt_q != '0) | (fifo_cnt_q != '0);

    always_comb begin
        inflight_cnt_d = inflight_cnt_q + CW'(issue) - CW'(ret);
        fifo_cnt_d     = fifo_cnt_q + CW'(ret) - CW'(pop);
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        if (ret) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_cnt_q <= '0;
            fifo_cnt_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            inflight_cnt_q <= inflight_cnt_d;
            fifo_cnt_q     <= fifo_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
        end
    end

    // Sideband rides alongside the SRAM access so it lines up with mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RL; i++) begin
                pipe_side_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_side_q[0] <= {m_info, m_first, m_last};
            for (int i = 1; i < RL; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_side_q[i] <= pipe_side_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ret) begin
            fifo_mem_q[wr_ptr_q] <= {mem_rdata, pipe_side_q[RL-1]};
        end
    end

endmodule

// File: tb/tb_dma_sram_reader.sv
// Bench for dma_sram_reader: RL=1 and RL=3 instances checked against an
// outstanding-word queue model with fixed return latency, plus directed literals.
`timescale 1ns/1ps
module tb_dma_sram_reader;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int IFW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [AW-1:0]  m_addr    [2];
    logic [IFW-1:0] m_info    [2];
    logic           m_first   [2];
    logic           m_last    [2];
    logic           m_valid   [2];
    logic           m_ready   [2];
    logic           mem_en    [2];
    logic [AW-1:0]  mem_addr  [2];
    logic [DW-1:0]  mem_rdata [2];
    logic [DW-1:0]  s_data    [2];
    logic [IFW-1:0] s_info    [2];
    logic           s_first   [2];
    logic           s_last    [2];
    logic           s_valid   [2];
    logic           s_ready   [2];
    logic           busy      [2];

    always #5 clk = ~clk;

    dma_sram_reader #(.AW(AW), .DW(DW), .IFW(IFW), .RL(1)) u_dut_rl1 (
        .clk(clk), .rst_n(rst_n),
        .m_addr(m_addr[0]), .m_info(m_info[0]), .m_first(m_first[0]), .m_last(m_last[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
        .s_data(s_data[0]), .s_info(s_info[0]), .s_first(s_first[0]), .s_last(s_last[0]),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .busy(busy[0])
    );

    dma_sram_reader #(.AW(AW), .DW(DW), .IFW(IFW), .RL(3)) u_dut_rl3 (
        .clk(clk), .rst_n(rst_n),
        .m_addr(m_addr[1]), .m_info(m_info[1]), .m_first(m_first[1]), .m_last(m_last[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
        .s_data(s_data[1]), .s_info(s_info[1]), .s_first(s_first[1]), .s_last(s_last[1]),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .busy(busy[1])
    );

    function automatic int rl_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a == 14'h0010) ? 32'hDEADBEEF : DW'(a) * 32'd3;
    endfunction

    // SRAM model: word appears on mem_rdata exactly RL cycles after mem_en.
    logic [DW-1:0] mr [2][3];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mr[k][0] <= mem_en[k] ? mem_word(mem_addr[k]) : 32'hBAD0_0000;
            mr[k][1] <= mr[k][0];
            mr[k][2] <= mr[k][1];
        end
    end
    assign mem_rdata[0] = mr[0][0];
    assign mem_rdata[1] = mr[1][2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s rl%0d cyc=%0d actual=0x%0h required=0x%0h", name, rl_of(k), cyc, act, exp);
        end
    endtask

    // Model: every accepted request is an outstanding word due at accept_cycle+RL+1,
    // delivered in order; credit limit is RL+2 outstanding words.
    typedef struct {
        logic [DW-1:0]  data;
        logic [IFW-1:0] info;
        logic           first;
        logic           last;
        int             due;
    } exp_t;

    exp_t ring [2][64];
    int   head [2] = '{0, 0};
    int   tail [2] = '{0, 0};
    int   pops [2] = '{0, 0};

    task automatic check_inst(input int k);
        exp_t e;
        int   occ;
        logic exp_sv, exp_mr;
        if (!rst_n) begin
            head[k] = 0;
            tail[k] = 0;
            cmp("rst_s_valid", k, s_valid[k], 0);
            cmp("rst_busy", k, busy[k], 0);
            return;
        end
        occ    = tail[k] - head[k];
        e      = ring[k][head[k] % 64];
        exp_sv = (occ != 0) && (e.due <= cyc);
        exp_mr = (occ < rl_of(k) + 2);
        cmp("s_valid", k, s_valid[k], exp_sv);
        cmp("m_ready", k, m_ready[k], exp_mr);
        cmp("busy", k, busy[k], occ != 0);
        cmp("mem_en", k, mem_en[k], m_valid[k] & exp_mr);
        if (m_valid[k] && exp_mr) cmp("mem_addr", k, mem_addr[k], m_addr[k]);
        if (exp_sv && s_valid[k] && s_ready[k]) begin
            cmp("s_data", k, s_data[k], e.data);
            cmp("s_info", k, s_info[k], e.info);
            cmp("s_first", k, s_first[k], e.first);
            cmp("s_last", k, s_last[k], e.last);
            head[k]++;
            pops[k]++;
        end
        if (m_valid[k] && exp_mr) begin
            e.data  = mem_word(m_addr[k]);
            e.info  = m_info[k];
            e.first = m_first[k];
            e.last  = m_last[k];
            e.due   = cyc + rl_of(k) + 1;
            ring[k][tail[k] % 64] = e;
            tail[k]++;
        end
    endtask

    always @(negedge clk) begin
        check_inst(0);
        check_inst(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [AW-1:0] a, input logic [IFW-1:0] inf,
                         input logic f, input logic l, input logic v);
        m_addr[k]  = a;
        m_info[k]  = inf;
        m_first[k] = f;
        m_last[k]  = l;
        m_valid[k] = v;
    endtask

    task automatic random_run(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            drive(k, AW'($urandom()), IFW'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
            s_ready[k] = 1'($urandom());
            step();
        end
        m_valid[k] = 1'b0;
        s_ready[k] = 1'b1;
        for (int n2 = 0; n2 < 20 && busy[k]; n2++) step();
        cmp("drain_busy", k, busy[k], 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int drops, acc, p0, c0, first_out;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(k, '0, '0, 1'b0, 1'b0, 1'b0);
            s_ready[k] = 1'b0;
        end
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        cmp("reset_m_ready", 0, m_ready[0], 1);
        cmp("reset_s_valid", 0, s_valid[0], 0);
        step();

        // Single beat, RL=1
        s_ready[0] = 1'b1;
        drive(0, 14'h0010, 4'h5, 1'b1, 1'b1, 1'b1);
        #1;
        cmp("single_mem_en", 0, mem_en[0], 1);
        cmp("single_mem_addr", 0, mem_addr[0], 14'h0010);
        step();
        m_valid[0] = 1'b0;
        #1;
        cmp("single_busy_c1", 0, busy[0], 1);
        cmp("single_s_valid_c1", 0, s_valid[0], 0);
        step();
        #1;
        cmp("single_s_valid_c2", 0, s_valid[0], 1);
        cmp("single_s_data", 0, s_data[0], 32'hDEADBEEF);
        cmp("single_s_info", 0, s_info[0], 4'h5);
        cmp("single_s_first", 0, s_first[0], 1);
        cmp("single_s_last", 0, s_last[0], 1);
        cmp("single_busy_c2", 0, busy[0], 1);
        step();
        #1;
        cmp("single_busy_after", 0, busy[0], 0);

        // Streaming 16 beats, RL=1
        drops = 0;
        p0    = pops[0];
        for (int i = 0; i < 16; i++) begin
            drive(0, AW'(i), IFW'(i), i == 0, i == 15, 1'b1);
            #1;
            if (!m_ready[0]) drops++;
            if (i == 2) begin
                cmp("stream_beat0_data", 0, s_data[0], 0);
                cmp("stream_beat0_first", 0, s_first[0], 1);
            end
            if (i == 15) begin
                cmp("stream_beat13_data", 0, s_data[0], 39);
                cmp("stream_beat13_last", 0, s_last[0], 0);
            end
            step();
        end
        m_valid[0] = 1'b0;
        repeat (3) step();
        cmp("stream_m_ready_drops", 0, drops, 0);
        cmp("stream_pops", 0, pops[0] - p0, 16);

        // Backpressure, RL=1
        s_ready[0] = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, AW'(14'h0020 + acc), 4'h3, 1'b0, 1'b0, 1'b1);
            #1;
            if (m_ready[0]) acc++;
            step();
        end
        cmp("bp_accepted", 0, acc, 3);
        cmp("bp_m_ready_low", 0, m_ready[0], 0);
        p0         = pops[0];
        m_valid[0] = 1'b0;
        s_ready[0] = 1'b1;
        #1;
        cmp("bp_m_ready_at_pop", 0, m_ready[0], 0);
        cmp("bp_head_data", 0, s_data[0], 32'h60);
        step();
        #1;
        cmp("bp_m_ready_after_pop", 0, m_ready[0], 1);
        step();
        step();
        cmp("bp_drained", 0, pops[0] - p0, 3);

        // Random handshake, RL=1
        random_run(0, 100);

        // Reset with one read in flight and two buffered
        s_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, AW'(14'h0040 + i), 4'h1, 1'b0, 1'b0, 1'b1);
            step();
        end
        m_valid[0] = 1'b0;
        #1;
        cmp("prerst_s_valid", 0, s_valid[0], 1);
        cmp("prerst_busy", 0, busy[0], 1);
        #1;
        rst_n = 1'b0;
        #1;
        cmp("midrst_s_valid", 0, s_valid[0], 0);
        cmp("midrst_busy", 0, busy[0], 0);
        step();
        step();
        rst_n      = 1'b1;
        s_ready[0] = 1'b1;
        repeat (4) step();
        cmp("postrst_s_valid", 0, s_valid[0], 0);
        drive(0, 14'h0077, 4'hA, 1'b1, 1'b1, 1'b1);
        step();
        m_valid[0] = 1'b0;
        step();
        #1;
        cmp("postrst_s_valid_new", 0, s_valid[0], 1);
        cmp("postrst_s_data", 0, s_data[0], 32'h165);
        cmp("postrst_s_info", 0, s_info[0], 4'hA);
        step();

        // RL=3 streaming 32 beats
        s_ready[1] = 1'b1;
        drops      = 0;
        first_out  = -1;
        c0         = 0;
        p0         = pops[1];
        for (int i = 0; i < 32; i++) begin
            drive(1, AW'(14'h0100 + i), IFW'(i), i == 0, i == 31, 1'b1);
            #1;
            if (i == 0) c0 = cyc;
            if (!m_ready[1]) drops++;
            if (s_valid[1] && first_out < 0) first_out = cyc;
            if (i == 4) cmp("rl3_beat0_data", 1, s_data[1], 32'h300);
            step();
        end
        m_valid[1] = 1'b0;
        repeat (6) step();
        cmp("rl3_m_ready_drops", 1, drops, 0);
        cmp("rl3_latency", 1, first_out - c0, 4);
        cmp("rl3_pops", 1, pops[1] - p0, 32);

        // Random handshake, RL=3
        random_run(1, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_sram_reader.md
Name: dma_sram_reader

Overview:
- Consumer end of the DMA address-generator stream.
- Accepts the address/info/first/last handshake stream and issues SRAM reads with a fixed, parameterised read latency.
- Returns read data as a valid/ready stream, with info/first/last aligned to each word.
- Credit counting plus an output FIFO sustain one word per cycle and absorb downstream backpressure without loss.

Parameters:
- AW, 14, address width; matches the generator address width.
- DW, 32, SRAM data width.
- IFW, 4, sideband info width; passed through unchanged.
- RL, 1, SRAM read latency in cycles; legal range 1..3.
- FD, RL+2, output FIFO depth and credit limit; derived, not overridable.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_addr  in  AW  read address from generator.
- m_info  in  IFW  sideband info.
- m_first  in  1  first beat of block.
- m_last  in  1  last beat of block.
- m_valid  in  1  request valid.
- m_ready  out  1  request accepted when m_valid & m_ready.
- mem_en  out  1  SRAM read enable.
- mem_addr  out  AW  SRAM read address.
- mem_rdata  in  DW  SRAM read data, valid RL cycles after mem_en.
- s_data  out  DW  returned word.
- s_info  out  IFW  info aligned to s_data.
- s_first  out  1  first flag aligned to s_data.
- s_last  out  1  last flag aligned to s_data.
- s_valid  out  1  output valid.
- s_ready  in  1  downstream ready.
- busy  out  1  high while any read is in flight or the FIFO is non-empty.

Behaviour:
- Reset (async, rst_n low): clear inflight pipe, FIFO pointers and counters.
  - s_valid=0, mem_en=0, busy=0.
  - s_data/s_info/s_first/s_last are don't-care while s_valid=0.
  - m_ready is combinational from the counters, so it reads 1 once reset.
  - Reset mid-operation discards all in-flight and buffered words; no stale beat appears after release.
- Credit:
  - inflight_cnt counts reads issued but not yet written to the FIFO; fifo_cnt counts buffered words.
  - m_ready = (inflight_cnt + fifo_cnt) < FD.
  - m_ready must NOT depend combinationally on s_ready. This avoids a comb path through the block.
- Issue:
  - mem_en = m_valid & m_ready; mem_addr = m_addr (both combinational).
  - At the same edge, push {valid, info, first, last} into an RL-stage shift register.
- Return:
  - When stage RL is valid, write {mem_rdata, info, first, last} into the FIFO at the end of that cycle.
  - inflight_cnt decrements on this write and increments on issue; simultaneous issue and return leaves it unchanged.
- Output:
  - s_valid = fifo_cnt != 0; FIFO head drives s_data/s_info/s_first/s_last.
  - Pop on s_valid & s_ready.
  - Simultaneous push and pop leaves fifo_cnt unchanged. Push into a full FIFO cannot occur because of the credit rule.
  - Pop on empty is impossible, since s_valid=0.
- Latency: request accepted in cycle 0 → mem_rdata sampled in cycle RL → s_valid in cycle RL+1.
- Throughput: one word per cycle sustained when s_ready=1. Steady-state occupancy is RL+1 < FD.
- Ordering: strictly in-order; first/last/info never reordered or modified.
- Pointer wrap: FIFO pointers wrap modulo FD; FD need not be a power of two.
- busy = (inflight_cnt != 0) | (fifo_cnt != 0); registered-state derived, no comb input path.
- Counter widths: sized to hold FD exactly; no overflow possible.

Test Plan:
- Single beat, RL=1: m_addr=0x0010, m_first=m_last=1, m_info=0x5 accepted in cycle 0 → mem_en=1, mem_addr=0x0010 in cycle 0; mem_rdata=0xDEADBEEF in cycle 1 → s_valid=1 in cycle 2 with s_data=0xDEADBEEF, s_info=0x5, first=last=1; busy high in cycles 1–2, low after the pop.
- Streaming: 16 consecutive beats, addresses 0..15, s_ready=1, memory model returns addr*3 → m_ready never drops; outputs 0,3,...,45 one per cycle; first on beat 0 only, last on beat 15 only.
- Backpressure, RL=1 (FD=3): s_ready=0 with continuous m_valid → exactly 3 requests accepted, then m_ready=0 and stays low. Raise s_ready → 3 words drain in order; m_ready reasserts the cycle after the first pop.
- Simultaneous push/pop: fifo_cnt=1 and a return arrives while s_ready=1 → fifo_cnt stays 1; no word lost or duplicated across 100 randomised s_ready/m_valid cycles, checked by a scoreboard.
- Reset mid-op: assert rst_n low with 1 read in flight and 2 buffered → s_valid=0 and busy=0 immediately. After release, no output until a new request; the new request returns correctly.
- RL=3 build (FD=5): 32-beat stream with s_ready=1 → latency 4 cycles, one word per cycle, m_ready constant 1. Random s_ready at 50% → scoreboard clean and occupancy never exceeds 5.
